// File: rtl/imm_ext_pkg.sv
// Shared immediate-extension definitions: extension modes and the default
// immediate/word widths also used by the instruction decoder.
package imm_ext_pkg;

   localparam int IMM_W  = 21;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      SEXT     = 2'd0,
      ZEXT     = 2'd1,
      SEXT_SHL = 2'd2,
      UPPER    = 2'd3
   } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: (imm, mode) -> (word, ovf).
// Only the shifted-offset mode can lose information, so only it raises ovf.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W,
   parameter int SHIFT = 2
) (
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] word,
   output logic             ovf
);

   imm_mode_e              mode_e;
   logic [OUT_W-1:0]       sext_word;
   logic [OUT_W-1:0]       zext_word;
   logic [OUT_W-1:0]       upper_word;
   logic [OUT_W+SHIFT-1:0] shl_wide;
   logic [SHIFT:0]         shl_top;
   logic                   shl_ovf;

   assign mode_e     = imm_mode_e'(mode);
   assign sext_word  = OUT_W'(signed'(imm));
   assign zext_word  = OUT_W'(imm);
   assign upper_word = zext_word << (OUT_W - IN_W);
   assign shl_wide   = (OUT_W + SHIFT)'(signed'(imm)) << SHIFT;

   // Discarded bits plus the kept MSB must all agree, otherwise the scaled
   // offset no longer fits in the output word.
   assign shl_top = (SHIFT + 1)'(shl_wide >> (OUT_W - 1));
   assign shl_ovf = !((shl_top == '0) || (shl_top == '1));

   always_comb begin
      word = sext_word;
      ovf  = 1'b0;
      case (mode_e)
         SEXT:     word = sext_word;
         ZEXT:     word = zext_word;
         SEXT_SHL: begin
            word = shl_wide[OUT_W-1:0];
            ovf  = shl_ovf;
         end
         UPPER:    word = upper_word;
         default:  word = sext_word;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate-extension pipeline with valid/ready handshake and a
// sticky truncation flag; sits between decode and the ALU operand mux.
module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W,
   parameter int SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_word,
   output logic             out_ovf,
   output logic             ovf_sticky,
   input  logic             ovf_clr
);

   logic             s1_valid;
   logic [IN_W-1:0]  s1_imm;
   logic [1:0]       s1_mode;
   logic             s2_valid;
   logic [OUT_W-1:0] s2_word;
   logic             s2_ovf;
   logic             s2_load;
   logic             s1_load;
   logic [OUT_W-1:0] core_word;
   logic             core_ovf;

   // No skid buffer: in_ready follows out_ready combinationally when full.
   assign s2_load  = !s2_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_core (
      .imm  (s1_imm),
      .mode (s1_mode),
      .word (core_word),
      .ovf  (core_ovf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_imm   <= '0;
         s1_mode  <= '0;
         s2_valid <= 1'b0;
         s2_word  <= '0;
         s2_ovf   <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_imm  <= in_imm;
               s1_mode <= in_mode;
            end
         end
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_word <= core_word;
               s2_ovf  <= core_ovf;
            end
         end
      end
   end

   // A set from an overflowing transfer beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
      end else if (s2_valid && out_ready && s2_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky <= 1'b0;
      end
   end

   assign out_valid = s2_valid;
   assign out_word  = s2_word;
   assign out_ovf   = s2_ovf;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed mode checks, overflow
// flag behaviour, backpressure, random traffic against a scoreboard, reset.
module tb_imm_extend_pipe;

   typedef struct {
      logic [63:0] word;
      bit          ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic        a_out_ovf, a_ovf_sticky, a_ovf_clr;
   logic [20:0] a_in_imm;
   logic [1:0]  a_in_mode;
   logic [31:0] a_out_word;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic        b_out_ovf, b_ovf_sticky, b_ovf_clr;
   logic [15:0] b_in_imm;
   logic [1:0]  b_in_mode;
   logic [16:0] b_out_word;

   int vectors = 0;
   int miscompares = 0;

   imm_extend_pipe dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (a_in_valid),
      .in_ready   (a_in_ready),
      .in_imm     (a_in_imm),
      .in_mode    (a_in_mode),
      .out_valid  (a_out_valid),
      .out_ready  (a_out_ready),
      .out_word   (a_out_word),
      .out_ovf    (a_out_ovf),
      .ovf_sticky (a_ovf_sticky),
      .ovf_clr    (a_ovf_clr)
   );

   imm_extend_pipe #(.IN_W(16), .OUT_W(17), .SHIFT(2)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (b_in_valid),
      .in_ready   (b_in_ready),
      .in_imm     (b_in_imm),
      .in_mode    (b_in_mode),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
      .out_word   (b_out_word),
      .out_ovf    (b_out_ovf),
      .ovf_sticky (b_ovf_sticky),
      .ovf_clr    (b_ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: interpret the immediate as a number and apply the mode's
   // arithmetic meaning, then wrap to the output width.
   function automatic exp_t model(input logic [63:0] imm, input int mode,
                                  input int iw, input int ow, input int sh);
      longint u, s, p, mask;
      exp_t   e;
      u    = longint'(imm) & ((64'sd1 << iw) - 1);
      s    = (((u >> (iw - 1)) & 1) != 0) ? u - (64'sd1 << iw) : u;
      mask = (64'sd1 << ow) - 1;
      e.ovf = 1'b0;
      case (mode)
         0: e.word = s & mask;
         1: e.word = u;
         2: begin
            p      = s * (64'sd1 << sh);
            e.word = p & mask;
            e.ovf  = (p < -(64'sd1 << (ow - 1))) || (p >= (64'sd1 << (ow - 1)));
         end
         default: e.word = (u << (ow - iw)) & mask;
      endcase
      return e;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (a_out_valid !== 1'b0 || a_out_word !== 32'h0 || a_out_ovf !== 1'b0 || a_ovf_sticky !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_a: valid=%b word=%h ovf=%b sticky=%b, required 0 0 0 0",
                  a_out_valid, a_out_word, a_out_ovf, a_ovf_sticky);
      end
      vectors++;
      if (b_out_valid !== 1'b0 || b_out_word !== 17'h0 || b_out_ovf !== 1'b0 || b_ovf_sticky !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_b: valid=%b word=%h ovf=%b sticky=%b, required 0 0 0 0",
                  b_out_valid, b_out_word, b_out_ovf, b_ovf_sticky);
      end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_ready: a=%b b=%b, required 1 1", a_in_ready, b_in_ready);
      end
   endtask

   task automatic test_directed();
      logic [20:0] imms [4] = '{21'h100000, 21'h100000, 21'h1FFFFF, 21'h000001};
      logic [31:0] words[4] = '{32'hFFF00000, 32'h00100000, 32'hFFFFFFFC, 32'h00000800};
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_in_valid = 1'b1;
         a_in_imm   = imms[i];
         a_in_mode  = 2'(i);
         #1;
         vectors++;
         if (a_in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL directed_ready[%0d]: in_ready=%b, required 1", i, a_in_ready);
         end
         @(posedge clk);
         @(negedge clk);
         a_in_valid = 1'b0;
         vectors++;
         if (a_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL directed_early[%0d]: out_valid=%b one edge after accept, required 0", i, a_out_valid);
         end
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if (a_out_valid !== 1'b1 || a_out_word !== words[i] || a_out_ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL directed_mode%0d: valid=%b word=%h ovf=%b, required 1 %h 0",
                     i, a_out_valid, a_out_word, a_out_ovf, words[i]);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_ovf_sticky();
      b_out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         b_in_valid = 1'b1;
         b_in_imm   = 16'h4000;
         b_in_mode  = 2'd2;
         @(posedge clk);
         @(negedge clk);
         b_in_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if (b_out_valid !== 1'b1 || b_out_word !== 17'h10000 || b_out_ovf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL shl_ovf_beat[%0d]: valid=%b word=%h ovf=%b, required 1 10000 1",
                     k, b_out_valid, b_out_word, b_out_ovf);
         end
         b_ovf_clr = (k == 1);
         @(posedge clk);
         @(negedge clk);
         b_ovf_clr = 1'b0;
         vectors++;
         if (b_ovf_sticky !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sticky_set[%0d] (clr=%0d): sticky=%b, required 1", k, k, b_ovf_sticky);
         end
         b_ovf_clr = 1'b1;
         @(posedge clk);
         @(negedge clk);
         b_ovf_clr = 1'b0;
         vectors++;
         if (b_ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sticky_clr[%0d]: sticky=%b, required 0", k, b_ovf_sticky);
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t        q[$];
      exp_t        e;
      logic [20:0] imms [4];
      int          modes[4];
      int          acc = 0;
      int          got = 0;
      for (int i = 0; i < 4; i++) begin
         imms[i]  = 21'($urandom);
         modes[i] = int'($urandom_range(0, 3));
      end
      for (int c = 0; c < 40 && got < 4; c++) begin
         a_out_ready = (c >= 5);
         a_in_valid  = (acc < 4);
         a_in_imm    = imms[acc < 4 ? acc : 0];
         a_in_mode   = 2'(modes[acc < 4 ? acc : 0]);
         #1;
         if (c == 2) begin
            vectors++;
            if (acc != 2) begin
               miscompares++;
               $display("[TB] FAIL bp_accepted: %0d beats accepted before full, required 2", acc);
            end
         end
         if (c >= 2 && c < 5) begin
            vectors++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_word !== q[0].word[31:0]) begin
               miscompares++;
               $display("[TB] FAIL bp_hold[c%0d]: in_ready=%b out_valid=%b word=%h, required 0 1 %h",
                        c, a_in_ready, a_out_valid, a_out_word, q[0].word[31:0]);
            end
         end
         if (a_out_valid && a_out_ready) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL bp_extra: unexpected beat word=%h, required none", a_out_word);
            end else begin
               e = q.pop_front();
               if (64'(a_out_word) !== e.word || a_out_ovf !== e.ovf) begin
                  miscompares++;
                  $display("[TB] FAIL bp_order[%0d]: word=%h ovf=%b, required %h %b",
                           got, a_out_word, a_out_ovf, e.word[31:0], e.ovf);
               end
            end
            got++;
         end
         if (a_in_valid && a_in_ready) begin
            q.push_back(model(64'(a_in_imm), int'(a_in_mode), 21, 32, 2));
            acc++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      vectors++;
      if (got != 4) begin
         miscompares++;
         $display("[TB] FAIL bp_count: %0d beats received, required 4", got);
      end
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if (a_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_duplicate[%0d]: out_valid=%b, required 0", c, a_out_valid);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      localparam int NBEATS = 1200;
      exp_t        q[$];
      exp_t        e;
      int          sent = 0;
      int          recv = 0;
      int          cyc = 0;
      bit          prev_stall = 0;
      logic [31:0] prev_word = '0;
      logic        prev_ovf = 1'b0;
      while (recv < NBEATS && cyc < 20000) begin
         if (prev_stall) begin
            vectors++;
            if (a_out_valid !== 1'b1 || a_out_word !== prev_word || a_out_ovf !== prev_ovf) begin
               miscompares++;
               $display("[TB] FAIL rand_stable[cyc%0d]: valid=%b word=%h ovf=%b, required 1 %h %b",
                        cyc, a_out_valid, a_out_word, a_out_ovf, prev_word, prev_ovf);
            end
         end
         a_out_ready = ($urandom_range(0, 9) < 7);
         a_in_valid  = (sent < NBEATS) && ($urandom_range(0, 9) < 7);
         a_in_imm    = 21'($urandom);
         a_in_mode   = 2'($urandom_range(0, 3));
         #1;
         if (a_out_valid && a_out_ready) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL rand_extra[cyc%0d]: unexpected word=%h, required none", cyc, a_out_word);
            end else begin
               e = q.pop_front();
               if (64'(a_out_word) !== e.word || a_out_ovf !== e.ovf) begin
                  miscompares++;
                  $display("[TB] FAIL rand_beat[%0d]: word=%h ovf=%b, required %h %b",
                           recv, a_out_word, a_out_ovf, e.word[31:0], e.ovf);
               end
            end
            recv++;
         end
         if (a_in_valid && a_in_ready) begin
            q.push_back(model(64'(a_in_imm), int'(a_in_mode), 21, 32, 2));
            sent++;
         end
         prev_stall = a_out_valid && !a_out_ready;
         prev_word  = a_out_word;
         prev_ovf   = a_out_ovf;
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      a_in_valid = 1'b0;
      vectors++;
      if (recv != NBEATS) begin
         miscompares++;
         $display("[TB] FAIL rand_timeout: %0d beats received, required %0d", recv, NBEATS);
      end
   endtask

   task automatic test_reset_midflight();
      a_out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         a_in_valid = 1'b1;
         a_in_imm   = 21'($urandom);
         a_in_mode  = 2'($urandom_range(0, 3));
         @(posedge clk);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      rst_n      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_word !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL midreset: valid=%b in_ready=%b word=%h, required 0 1 0",
                  a_out_valid, a_in_ready, a_out_word);
      end
      rst_n       = 1'b1;
      a_out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if (a_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_stale[%0d]: out_valid=%b, required 0", c, a_out_valid);
         end
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      a_in_valid  = 1'b0;
      a_in_imm    = '0;
      a_in_mode   = '0;
      a_out_ready = 1'b0;
      a_ovf_clr   = 1'b0;
      b_in_valid  = 1'b0;
      b_in_imm    = '0;
      b_in_mode   = '0;
      b_out_ready = 1'b0;
      b_ovf_clr   = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_ovf_sticky();
      test_backpressure();
      test_random();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit: widens an IN_W-bit instruction immediate to an OUT_W-bit datapath word in one of four modes (sign, zero, sign-and-shift, upper-place). It sits between instruction decode and the ALU/branch-target operand mux. A valid/ready handshake lets it stall with the decode pipeline. A sticky overflow flag reports shifted-offset truncation.

## Interface
- IN_W, 21, immediate input width; 1 ≤ IN_W ≤ OUT_W
- OUT_W, 32, output word width
- SHIFT, 2, left shift applied in mode SEXT_SHL (word-offset scaling); 0 ≤ SHIFT < OUT_W
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  unit accepts beat this cycle
- in_imm  in  IN_W  raw immediate
- in_mode  in  2  extension mode: 0 SEXT, 1 ZEXT, 2 SEXT_SHL, 3 UPPER
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- out_word  out  OUT_W  extended result
- out_ovf  out  1  per-beat truncation indicator, qualified by out_valid
- ovf_sticky  out  1  set by any accepted output beat with out_ovf=1
- ovf_clr  in  1  clears ovf_sticky

## Operation
- Transfer occurs on a side when valid && ready in the same cycle.
- Stage 1 (S1) registers in_imm and in_mode. Stage 2 (S2) registers the computed word and per-beat overflow.
- SEXT: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
- ZEXT: zero-fill the upper bits.
- SEXT_SHL: sign-extend to OUT_W+SHIFT bits, shift left by SHIFT, keep the low OUT_W bits. out_ovf=1 when the discarded upper SHIFT bits are not all equal to the kept MSB.
- UPPER: out_word = {in_imm, (OUT_W-IN_W) zeros}.
- out_ovf=0 in every mode except SEXT_SHL.
- When IN_W == OUT_W, SEXT, ZEXT and UPPER pass in_imm unchanged.
- Stage advance:
  - S2 loads when !s2_valid || out_ready.
  - S1 loads when !s1_valid || S2 loads.
  - in_ready equals the S1-load condition. This is a combinational path from out_ready; no skid buffer.
- Stalled stages hold data unchanged. While out_valid=1 and out_ready=0, out_word and out_ovf must not change.
- ovf_sticky: set on an output transfer with out_ovf=1. ovf_clr clears it. If both occur in the same cycle, the set wins.

## Timing
- Reset (rst_n=0 at an edge): s1_valid=0, s2_valid=0, out_valid=0, out_word=0, out_ovf=0, ovf_sticky=0.
- in_ready is 1 in the first cycle after reset.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+1. That is 2 edges from in_valid to out_valid with no stall.
- Throughput: one beat per cycle while out_ready=1.
- Full condition: both stages valid and out_ready=0 gives in_ready=0. The unit buffers at most 2 beats.
- Reset mid-operation drops all in-flight beats; nothing is emitted afterwards for them.
- ovf_clr is honoured regardless of handshake state.

## Structure
- Shared package imm_ext_pkg holds:
  - the mode enum (SEXT=2'd0, ZEXT=2'd1, SEXT_SHL=2'd2, UPPER=2'd3)
  - default width constants IMM_W=21 and WORD_W=32, reused by the decoder.
- One sub-module, imm_ext_core: purely combinational (imm, mode) -> (word, ovf), parametrised by IN_W, OUT_W and SHIFT. It is instantiated between S1 and S2.
- Top level holds the stage registers, handshake logic and sticky flag.

## Test plan
- Defaults, out_ready=1: SEXT 21'h100000 -> 32'hFFF00000; ZEXT 21'h100000 -> 32'h00100000; both ovf=0, each 2 edges after acceptance.
- Defaults: SEXT_SHL 21'h1FFFFF -> 32'hFFFFFFFC, ovf=0; UPPER 21'h000001 -> 32'h00000800.
- IN_W=16, OUT_W=17, SHIFT=2: SEXT_SHL 16'h4000 -> 17'h10000, out_ovf=1, ovf_sticky=1 after transfer; ovf_clr and a simultaneous ovf beat -> ovf_sticky stays 1.
- Backpressure: stream 4 beats, hold out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepted beats; out_word stays stable.
  - On release, all 4 beats emerge in order with none lost or duplicated.
- Random valid/ready (≥1000 beats, all modes) vs scoreboard model: exact order and values.
- Assert rst_n=0 with 2 beats in flight -> out_valid=0 next cycle, in_ready=1, no stale beat emitted.
